// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 3x4 matrix keypad scanner:
//   - FSM state encoding for the press tracker
//   - key code constants for the row-3 specials
//   - row/column to key code lookup
//   - one-hot column drive constants
package keypad_pkg;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LOCKED   = 2'd2
    } kp_state_t;

    localparam logic [3:0] KEY_ZERO = 4'd0;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [2:0] COL0_ONEHOT = 3'b001;
    localparam logic [2:0] COL1_ONEHOT = 3'b010;
    localparam logic [2:0] COL2_ONEHOT = 3'b100;

    // Rows 0..2 form the 1..9 block; row 3 holds '*', '0', '#'.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = KEY_ZERO;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [2:0] col_onehot(input logic [1:0] idx);
        logic [2:0] drive;
        case (idx)
            2'd0:    drive = COL0_ONEHOT;
            2'd1:    drive = COL1_ONEHOT;
            default: drive = COL2_ONEHOT;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Accepts a full-keypad snapshot only after DEBOUNCE_FRAMES consecutive
//   identical frames.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-low reset
//   frame      : completed 12-bit snapshot, valid when frame_done is high
//   frame_done : one-cycle strobe marking a completed frame
//   stable     : last accepted snapshot
//   stable_upd : one-cycle strobe, high in the cycle stable holds a new acceptance
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] frame,
    input  logic                frame_done,
    output logic [NUM_KEYS-1:0] stable,
    output logic                stable_upd
);

    localparam logic [3:0] MATCH_MAX = 4'(DEBOUNCE_FRAMES);

    logic [NUM_KEYS-1:0] candidate;
    logic [3:0]          match_cnt;
    logic [3:0]          match_nxt;
    logic                same;
    logic                reach;

    always_comb begin
        same = (frame == candidate);
        if (!same) begin
            match_nxt = 4'd1;
        end else if (match_cnt == MATCH_MAX) begin
            match_nxt = MATCH_MAX;
        end else begin
            match_nxt = match_cnt + 4'd1;
        end
        // Acceptance happens only on the transition into MATCH_MAX. A new
        // candidate counts as a transition too, which matters when
        // DEBOUNCE_FRAMES is 1 and the counter sits at 1 already.
        reach = (match_nxt == MATCH_MAX) && (!same || (match_cnt != MATCH_MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            candidate  <= '0;
            match_cnt  <= 4'd0;
            stable     <= '0;
            stable_upd <= 1'b0;
        end else begin
            stable_upd <= 1'b0;
            if (frame_done) begin
                candidate <= frame;
                match_cnt <= match_nxt;
                if (reach) begin
                    stable     <= frame;
                    stable_upd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 3x4 matrix keypad, debounces complete 12-key snapshots and emits
//   one key event per clean press (no auto-repeat, multi-key presses locked out).
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : asynchronous active-low reset
//   KEY_COL   : one-hot column drive, active-high
//   KEY_ROW   : row sense, active-high, asynchronous to clk
//   key_valid : one-cycle pulse per accepted press
//   key_code  : code of the last accepted press, held until the next one
//   key_held  : high while the debounced snapshot has any key down
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] KEY_COL,
    input  logic [3:0] KEY_ROW,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]          row_p0;
    logic [3:0]          row_p1;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          col_idx;
    logic                sample;
    logic                frame_done;
    logic [NUM_KEYS-1:0] frame;
    logic [NUM_KEYS-1:0] frame_next;
    logic [NUM_KEYS-1:0] stable;
    logic                stable_upd;
    logic                stable_any;
    logic                stable_single;
    logic [1:0]          hit_row;
    logic [1:0]          hit_col;
    kp_state_t           state;

    // ---- stage p0/p1: row synchronizer ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_p0 <= 4'b0;
            row_p1 <= 4'b0;
        end else begin
            row_p0 <= KEY_ROW;
            row_p1 <= row_p0;
        end
    end

    // ---- column scan and frame assembly ----
    assign sample     = (div_cnt == DIV_LAST);
    assign frame_done = sample && (col_idx == 2'd2);
    assign KEY_COL    = col_onehot(col_idx);

    // The debouncer must see the frame including the column being sampled
    // right now, so the new rows are merged combinationally.
    always_comb begin
        frame_next = frame;
        case (col_idx)
            2'd0:    frame_next[3:0]  = row_p1;
            2'd1:    frame_next[7:4]  = row_p1;
            default: frame_next[11:8] = row_p1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            frame   <= '0;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            frame   <= frame_next;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame_next),
        .frame_done(frame_done),
        .stable    (stable),
        .stable_upd(stable_upd)
    );

    // ---- snapshot decode ----
    // Frame layout is column-major: bit col*4 + row.
    always_comb begin
        stable_any    = (stable != '0);
        stable_single = stable_any && ((stable & (stable - 12'd1)) == '0);
        hit_row       = 2'd0;
        hit_col       = 2'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (stable[i]) begin
                hit_col = 2'(i / NUM_ROWS);
                hit_row = 2'(i % NUM_ROWS);
            end
        end
    end

    // ---- press tracker FSM, outputs registered one cycle after stable ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RELEASED;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            key_held  <= stable_any;
            if (stable_upd) begin
                case (state)
                    RELEASED: begin
                        if (stable_single) begin
                            key_valid <= 1'b1;
                            key_code  <= key_lookup(hit_row, hit_col);
                            state     <= PRESSED;
                        end else if (stable_any) begin
                            state <= LOCKED;
                        end
                    end
                    PRESSED, LOCKED: begin
                        if (!stable_any) begin
                            state <= RELEASED;
                        end
                    end
                    default: state <= RELEASED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2
//   (12-cycle frame). A behavioural keypad drives KEY_ROW from KEY_COL and
//   a pressed-key mask indexed row*3+col.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int FRAME    = 3 * SCAN_DIV;

    localparam logic [11:0] KN    = 12'h000;
    localparam logic [11:0] K1    = 12'h001;
    localparam logic [11:0] K3    = 12'h004;
    localparam logic [11:0] K5    = 12'h010;
    localparam logic [11:0] K6    = 12'h020;
    localparam logic [11:0] K7    = 12'h040;
    localparam logic [11:0] KSTAR = 12'h200;
    localparam logic [11:0] K0    = 12'h400;
    localparam logic [11:0] KHASH = 12'h800;

    logic        clk;
    logic        rst;
    logic [2:0]  KEY_COL;
    logic [3:0]  KEY_ROW;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [11:0] keys;

    int checks;
    int errors;
    int total_pulses;
    int double_pulses;
    logic prev_valid;

    typedef struct {
        string       name;
        logic [11:0] keys;
        int          frames;
        int          pulses;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t vecs[15];

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .KEY_COL  (KEY_COL),
        .KEY_ROW  (KEY_ROW),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        KEY_ROW = 4'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (KEY_COL[c] && keys[r*3 + c]) KEY_ROW[r] = 1'b1;
            end
        end
    end

    initial begin
        total_pulses  = 0;
        double_pulses = 0;
        prev_valid    = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            total_pulses = total_pulses + 1;
            if (prev_valid === 1'b1) double_pulses = double_pulses + 1;
        end
        prev_valid = key_valid;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    initial begin
        int base;
        int lat;

        checks = 0;
        errors = 0;
        keys   = KN;
        rst    = 1'b0;

        vecs[0]  = '{"idle",         KN,      3,  0, 4'd0,  1'b0};
        vecs[1]  = '{"key5_hold",    K5,      10, 1, 4'd5,  1'b1};
        vecs[2]  = '{"key5_release", KN,      4,  0, 4'd5,  1'b0};
        vecs[3]  = '{"multi_1_3",    K1 | K3, 5,  0, 4'd5,  1'b1};
        vecs[4]  = '{"multi_keep_1", K1,      5,  0, 4'd5,  1'b1};
        vecs[5]  = '{"multi_release",KN,      4,  0, 4'd5,  1'b0};
        vecs[6]  = '{"hash",         KHASH,   5,  1, 4'd11, 1'b1};
        vecs[7]  = '{"hash_release", KN,      4,  0, 4'd11, 1'b0};
        vecs[8]  = '{"zero",         K0,      5,  1, 4'd0,  1'b1};
        vecs[9]  = '{"zero_release", KN,      4,  0, 4'd0,  1'b0};
        vecs[10] = '{"star",         KSTAR,   5,  1, 4'd10, 1'b1};
        vecs[11] = '{"star_release", KN,      4,  0, 4'd10, 1'b0};
        vecs[12] = '{"slide_from_5", K5,      5,  1, 4'd5,  1'b1};
        vecs[13] = '{"slide_to_6",   K6,      5,  0, 4'd5,  1'b1};
        vecs[14] = '{"slide_release",KN,      4,  0, 4'd5,  1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_key_col",   32'(KEY_COL),   32'(3'b001));
        check("reset_key_valid", 32'(key_valid), 32'd0);
        check("reset_key_code",  32'(key_code),  32'd0);
        check("reset_key_held",  32'(key_held),  32'd0);

        // Column scan: 4 cycles per column, 001 -> 010 -> 100 -> 001
        rst = 1'b1;
        #1;
        check("scan_col_0", 32'(KEY_COL), 32'd1);
        for (int j = 1; j <= 12; j++) begin
            logic [2:0] exp_col;
            @(negedge clk);
            exp_col = 3'b001 << ((j / SCAN_DIV) % 3);
            check($sformatf("scan_col_%0d", j), 32'(KEY_COL), 32'(exp_col));
        end

        // Table-driven press/release scenarios
        for (int v = 0; v < 15; v++) begin
            base = total_pulses;
            keys = vecs[v].keys;
            run_frames(vecs[v].frames);
            check({vecs[v].name, "_pulses"}, 32'(total_pulses - base), 32'(vecs[v].pulses));
            check({vecs[v].name, "_code"},   32'(key_code),            32'(vecs[v].code));
            check({vecs[v].name, "_held"},   32'(key_held),            32'(vecs[v].held));
        end

        // Bounce: key 1 on alternate frames never matches twice in a row
        base = total_pulses;
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? K1 : KN;
            run_frames(1);
        end
        check("bounce_pulses", 32'(total_pulses - base), 32'd0);
        check("bounce_held",   32'(key_held),            32'd0);
        base = total_pulses;
        keys = K1;
        run_frames(4);
        check("steady1_pulses", 32'(total_pulses - base), 32'd1);
        check("steady1_code",   32'(key_code),            32'd1);
        keys = KN;
        run_frames(4);

        // Reset in the middle of debouncing key 7
        base = total_pulses;
        keys = K7;
        run_frames(1);
        rst = 1'b0;
        #1;
        check("midrst_pulses",    32'(total_pulses - base), 32'd0);
        check("midrst_key_col",   32'(KEY_COL),             32'(3'b001));
        check("midrst_key_valid", 32'(key_valid),           32'd0);
        check("midrst_key_code",  32'(key_code),            32'd0);
        check("midrst_key_held",  32'(key_held),            32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // Frames complete on edges 12 and 24 after release; pulse on edge 25.
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("key7_latency", 32'(lat),      32'd25);
        check("key7_code",    32'(key_code), 32'd7);
        check("key7_held",    32'(key_held), 32'd1);
        keys = KN;
        run_frames(4);
        check("key7_release_held", 32'(key_held), 32'd0);

        check("pulse_width_one_cycle", 32'(double_pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
